clock_period_meter: RTL

CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

---
 rtl/clock_period_meter.sv | 118 +++++++++++
 1 files changed

// File: rtl/clock_period_meter.sv
// Measures the spacing between rising edges of an asynchronous strobe, in divisor
// form (spacing minus 1), with stability tracking and an optional inactivity timeout.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   IDLE    | no reference edge yet; waiting for the first one
//   MEASURE | counting cycles since the last accepted edge
module clock_period_meter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pulse_in,
    input  logic [WIDTH-1:0] timeout_cycles,
    input  logic [WIDTH-1:0] tolerance,
    output logic [WIDTH-1:0] period_out,
    output logic             period_stb,
    output logic             period_valid,
    output logic             period_stable,
    output logic             timeout_out
);

    typedef enum logic {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t            state;
    state_t            state_nx;
    logic              sync1;
    logic              sync2;
    logic              sync3;
    logic              edge_det;
    logic [WIDTH-1:0]  cnt;
    logic [WIDTH-1:0]  prev;
    logic              has_prev;
    logic [WIDTH-1:0]  diff;
    logic              do_arm;
    logic              do_stb;
    logic              do_timeout;
    logic              stable_nx;

    assign edge_det = sync2 & ~sync3;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (edge_det) state_nx = MEASURE;
            MEASURE: if (do_timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // An edge always beats a coincident timeout.
    always_comb begin
        do_arm     = 1'b0;
        do_stb     = 1'b0;
        do_timeout = 1'b0;
        diff       = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
        stable_nx  = has_prev && (diff <= tolerance);
        if (state == IDLE) begin
            do_arm = edge_det;
        end else if (edge_det) begin
            do_stb = 1'b1;
        end else if ((timeout_cycles != '0) && (cnt == timeout_cycles)) begin
            do_timeout = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            cnt           <= '0;
            prev          <= '0;
            has_prev      <= 1'b0;
            period_out    <= '0;
            period_stb    <= 1'b0;
            period_valid  <= 1'b0;
            period_stable <= 1'b0;
            timeout_out   <= 1'b0;
        end else begin
            sync1       <= pulse_in;
            sync2       <= sync1;
            sync3       <= sync2;
            period_stb  <= do_stb;
            timeout_out <= do_timeout;
            if (do_arm) begin
                cnt <= '0;
            end else if (do_stb) begin
                period_out    <= cnt;
                period_valid  <= 1'b1;
                period_stable <= stable_nx;
                prev          <= cnt;
                has_prev      <= 1'b1;
                cnt           <= '0;
            end else if (do_timeout) begin
                period_valid  <= 1'b0;
                period_stable <= 1'b0;
                has_prev      <= 1'b0;
            end else if ((state == MEASURE) && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
